gaussian_window_convolver: RTL and testbench

- Consumer stage directly downstream of the Gaussian kernel generator.
- Takes the normalized SIZE x SIZE kernel (Q0.8 coefficients, the generator's 8-bit output) when the generator's done pulse arrives.
- Accepts one SIZE x SIZE pixel window per valid/ready handshake and computes one multiply-accumulate per cycle.
- Produces one rounded, saturated 8-bit blurred pixel per window for the downstream FAST corner stage.

---
 rtl/gaussian_window_convolver.sv | 138 +++++++++++++
 tb/tb_gaussian_window_convolver.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_window_convolver.sv
// Gaussian blur stage: captures a Q0.8 kernel and convolves one SIZE x SIZE
// pixel window per handshake, one multiply-accumulate per cycle.
module gaussian_window_convolver #(
  parameter logic [3:0] SIZE = 4'd3
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic [SIZE-1:0][SIZE-1:0][7:0]  kernel,
  input  logic                            kernel_load,
  input  logic [SIZE-1:0][SIZE-1:0][7:0]  window,
  input  logic                            window_valid,
  output logic                            window_ready,
  output logic [7:0]                      pixel_out,
  output logic                            pixel_valid,
  input  logic                            pixel_ready,
  output logic                            busy,
  output logic                            err
);

  localparam int unsigned SZ = SIZE;
  localparam int unsigned N  = SZ * SZ;
  localparam int unsigned W  = N * 8;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] shadow_q, shadow_d;
  logic [W-1:0] kern_q, kern_d;
  logic [W-1:0] win_q, win_d;
  logic [23:0]  acc_q, acc_d;
  logic [7:0]   idx_q, idx_d;
  logic [7:0]   pix_q, pix_d;
  logic         pvalid_q, pvalid_d;
  logic         loaded_q, loaded_d;

  logic         hs;
  logic         last;
  logic [7:0]   cur_w, cur_k;
  logic [15:0]  prod;
  logic [23:0]  sum, rnd;
  logic [7:0]   sat;

  assign window_ready = (state_q == IDLE) && loaded_q;
  // Gated by reset so err reads 0 while n_rst is held low.
  assign err          = window_valid && !loaded_q && n_rst;
  assign busy         = (state_q == MAC) || (state_q == OUT);
  assign pixel_out    = pix_q;
  assign pixel_valid  = pvalid_q;
  assign hs           = window_valid && window_ready;
  assign last         = (idx_q == 8'(N - 1));

  // Packed [y][x][7:0] layout makes row-major tap i sit at bits [8i +: 8].
  always_comb begin
    cur_w = '0;
    cur_k = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_q == 8'(i)) begin
        cur_w = win_q[i*8 +: 8];
        cur_k = kern_q[i*8 +: 8];
      end
    end
  end

  assign prod = cur_w * cur_k;
  assign sum  = acc_q + {8'b0, prod};
  assign rnd  = sum + 24'd128;
  assign sat  = (rnd[23:16] != 8'd0) ? 8'hFF : rnd[15:8];

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    kern_d   = kern_q;
    win_d    = win_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    pix_d    = pix_q;
    pvalid_d = pvalid_q;
    loaded_d = loaded_q;

    if (kernel_load) begin
      shadow_d = kernel;
      loaded_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (hs) begin
          win_d   = window;
          kern_d  = kernel_load ? kernel : shadow_q;
          acc_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = sum;
        idx_d = idx_q + 8'd1;
        if (last) begin
          pix_d    = sat;
          pvalid_d = 1'b1;
          state_d  = OUT;
        end
      end
      OUT: begin
        if (pixel_ready) begin
          pvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      kern_q   <= '0;
      win_q    <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      pix_q    <= '0;
      pvalid_q <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      kern_q   <= kern_d;
      win_q    <= win_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      pix_q    <= pix_d;
      pvalid_q <= pvalid_d;
      loaded_q <= loaded_d;
    end
  end

endmodule

// File: tb/tb_gaussian_window_convolver.sv
// Bench for gaussian_window_convolver: directed scenarios plus random windows
// and kernels compared against an arithmetic reference convolution.
module tb_gaussian_window_convolver;

  localparam int S = 3;
  localparam int N = S * S;

  typedef logic [S-1:0][S-1:0][7:0] kt_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  kt_t        kernel = '0;
  logic       kernel_load = 1'b0;
  kt_t        window = '0;
  logic       window_valid = 1'b0;
  logic       window_ready;
  logic [7:0] pixel_out;
  logic       pixel_valid;
  logic       pixel_ready = 1'b0;
  logic       busy;
  logic       err;

  int unsigned errors = 0;
  int unsigned checks = 0;

  kt_t shadow_m;
  kt_t k28, kctr, kz, kw, kn;

  gaussian_window_convolver #(.SIZE(4'd3)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .kernel       (kernel),
    .kernel_load  (kernel_load),
    .window       (window),
    .window_valid (window_valid),
    .window_ready (window_ready),
    .pixel_out    (pixel_out),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned ref_pix(input kt_t k, input kt_t w);
    int unsigned s = 0;
    for (int y = 0; y < S; y++)
      for (int x = 0; x < S; x++)
        s += int'(k[y][x]) * int'(w[y][x]);
    s = (s + 128) / 256;
    return (s > 255) ? 255 : s;
  endfunction

  function automatic kt_t fill(input int unsigned v);
    kt_t k;
    for (int y = 0; y < S; y++)
      for (int x = 0; x < S; x++)
        k[y][x] = 8'(v);
    return k;
  endfunction

  function automatic kt_t rand_k(input int unsigned hi);
    kt_t k;
    for (int y = 0; y < S; y++)
      for (int x = 0; x < S; x++)
        k[y][x] = 8'($urandom_range(0, hi));
    return k;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, ".pixel_out"},    pixel_out, 0);
    check({tag, ".pixel_valid"},  pixel_valid, 0);
    check({tag, ".window_ready"}, window_ready, 0);
    check({tag, ".busy"},         busy, 0);
    check({tag, ".err"},          err, 0);
  endtask

  task automatic load_kernel(input kt_t k);
    kernel = k;
    kernel_load = 1'b1;
    @(negedge clk);
    kernel_load = 1'b0;
    shadow_m = k;
  endtask

  // Called at a negedge with the block idle and a kernel already held.
  task automatic do_window(input kt_t w, input int unsigned exp, input bit coload,
                           input kt_t newk, input int reload_at, input kt_t rk,
                           input int stall);
    int lat;
    check("ready_before_hs", window_ready, 1);
    window = w;
    window_valid = 1'b1;
    if (coload) begin
      kernel = newk;
      kernel_load = 1'b1;
    end
    @(negedge clk);
    window_valid = 1'b0;
    kernel_load = 1'b0;
    if (coload) shadow_m = newk;
    window = kt_t'($urandom());
    check("busy_in_mac", busy, 1);
    check("ready_in_mac", window_ready, 0);
    lat = 0;
    while (!pixel_valid && lat < 4 * N) begin
      pixel_ready = 1'($urandom());
      if (lat == reload_at) begin
        kernel = rk;
        kernel_load = 1'b1;
        shadow_m = rk;
      end else begin
        kernel_load = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    kernel_load = 1'b0;
    pixel_ready = 1'b0;
    check("latency", lat, N);
    check("pixel_out", pixel_out, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall.pixel_valid", pixel_valid, 1);
      check("stall.pixel_out", pixel_out, exp);
      check("stall.window_ready", window_ready, 0);
      check("stall.busy", busy, 1);
    end
    pixel_ready = 1'b1;
    @(negedge clk);
    pixel_ready = 1'b0;
    check("post.pixel_valid", pixel_valid, 0);
    check("post.window_ready", window_ready, 1);
    check("post.busy", busy, 0);
  endtask

  initial begin
    k28  = fill(28);
    kz   = '0;
    kctr = '0;
    kctr[1][1] = 8'd255;
    shadow_m = '0;

    // Reset with window_valid asserted, then no kernel yet.
    window_valid = 1'b1;
    window = fill(200);
    repeat (2) @(negedge clk);
    check_zero("reset");
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("nokernel.window_ready", window_ready, 0);
      check("nokernel.err", err, 1);
      check("nokernel.pixel_valid", pixel_valid, 0);
    end

    // First kernel arrives while a window is waiting.
    kernel = kctr;
    kernel_load = 1'b1;
    @(negedge clk);
    kernel_load = 1'b0;
    shadow_m = kctr;
    check("afterload.err", err, 0);
    check("afterload.window_ready", window_ready, 1);
    window_valid = 1'b0;

    do_window(fill(200), 199, 0, kz, -1, kz, 0);
    load_kernel(k28);
    do_window(fill(100), 98, 0, kz, -1, kz, 0);
    load_kernel(fill(255));
    do_window(fill(255), 255, 0, kz, -1, kz, 0);

    // Backpressure.
    load_kernel(kctr);
    do_window(fill(200), 199, 0, kz, -1, kz, 6);

    // Mid-MAC reload leaves the window in flight alone.
    load_kernel(k28);
    do_window(fill(100), 98, 0, kz, 3, kctr, 0);
    do_window(fill(200), 199, 0, kz, -1, kz, 0);
    // Coincident load bypasses into the working kernel.
    do_window(fill(100), 98, 1, k28, -1, kz, 0);
    do_window(fill(100), 100, 1, kctr, -1, kz, 0);

    // Reset during MAC discards the window.
    load_kernel(k28);
    window = fill(100);
    window_valid = 1'b1;
    @(negedge clk);
    window_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check_zero("midreset");
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postreset.window_ready", window_ready, 0);
      check("postreset.pixel_valid", pixel_valid, 0);
      check("postreset.busy", busy, 0);
    end
    load_kernel(k28);
    do_window(fill(100), 98, 0, kz, -1, kz, 0);

    // Random kernels and windows.
    for (int t = 0; t < 24; t++) begin
      int unsigned hi = ($urandom_range(0, 3) == 0) ? 255 : 40;
      kw = rand_k(255);
      if ($urandom_range(0, 2) == 0) load_kernel(rand_k(hi));
      if ($urandom_range(0, 3) == 0) begin
        kn = rand_k(hi);
        do_window(kw, ref_pix(kn, kw), 1, kn, -1, kz, int'($urandom_range(0, 3)));
      end else if ($urandom_range(0, 3) == 0) begin
        do_window(kw, ref_pix(shadow_m, kw), 0, kz, int'($urandom_range(1, N - 1)),
                  rand_k(hi), int'($urandom_range(0, 3)));
      end else begin
        do_window(kw, ref_pix(shadow_m, kw), 0, kz, -1, kz, int'($urandom_range(0, 3)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
